// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared definitions for the reset/clock-enable sequencer: FSM state
//   encodings, the state register width and a small helper used to size the
//   sequencing counter.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        SYNC  = 3'd0,
        HOLD  = 3'd1,
        RUN   = 3'd2,
        SOFT  = 3'd3,
        PAUSE = 3'd4
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// -----------------------------------------------------------------------------
// reset_synchronizer
//   Async-assert / sync-deassert reset generator. A shift register of ones is
//   cleared asynchronously by async_reset and refills one stage per clock, so
//   rst_n_out rises SYNC_STAGES rising edges after async_reset falls.
// Ports
//   clk         in  system clock, rising edge
//   async_reset in  asynchronous active-high reset
//   rst_n_out   out active-low reset, synchronously deasserted
// -----------------------------------------------------------------------------
module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_reset,
    output logic rst_n_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_n_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_enable_sequencer.sv
// -----------------------------------------------------------------------------
// reset_enable_sequencer
//   Source of reset and clock-enable for a clocked island. Turns a raw
//   asynchronous reset into a synchronised rst_n_out, a counted synchronous
//   reset pulse, a clock enable, and a glitch-free gated clock.
// Ports
//   clk            in  system clock, rising edge
//   async_reset    in  asynchronous active-high reset
//   soft_reset_req in  request a SOFT_CYCLES sync reset pulse (sampled in RUN)
//   pause_req      in  gate downstream clocks while high (RUN/PAUSE)
//   rst_n_out      out async-asserted, sync-deasserted active-low reset
//   sync_reset_out out active-high synchronous reset for downstream flops
//   clk_enable     out downstream clock enable
//   gclk           out gated clock, clk & en_lat
//   ready          out high only in RUN
// -----------------------------------------------------------------------------
module reset_enable_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int SOFT_CYCLES = 1
) (
    input  logic clk,
    input  logic async_reset,
    input  logic soft_reset_req,
    input  logic pause_req,
    output logic rst_n_out,
    output logic sync_reset_out,
    output logic clk_enable,
    output logic gclk,
    output logic ready
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, SOFT_CYCLES)) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               en_lat_q, en_lat_d;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk         (clk),
        .async_reset (async_reset),
        .rst_n_out   (rst_n_out)
    );

    // Next state, counter and Moore outputs, all decoded from state_q/cnt_q.
    // The counter is forced to zero in every state that does not count down.
    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        sync_reset_out = 1'b1;
        clk_enable     = 1'b0;
        ready          = 1'b0;
        case (state_q)
            SYNC: begin
                if (rst_n_out) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                clk_enable = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                sync_reset_out = 1'b0;
                clk_enable     = 1'b1;
                ready          = 1'b1;
                if (soft_reset_req) begin
                    state_d = SOFT;
                    cnt_d   = CNT_W'(SOFT_CYCLES - 1);
                end else if (pause_req) begin
                    state_d = PAUSE;
                end
            end
            SOFT: begin
                clk_enable = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PAUSE: begin
                sync_reset_out = 1'b0;
                if (!pause_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= SYNC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enable is captured while clk is low, so it can only change when the
    // AND gate's other input is already low: no runt pulses on gclk.
    always_comb begin
        en_lat_d = clk_enable;
    end

    always_ff @(negedge clk or posedge async_reset) begin
        if (async_reset) begin
            en_lat_q <= 1'b0;
        end else begin
            en_lat_q <= en_lat_d;
        end
    end

    assign gclk = clk & en_lat_q;

endmodule

// File: tb/tb_reset_enable_sequencer.sv
module tb_reset_enable_sequencer;

    logic clk = 1'b0;
    logic async_reset;
    logic soft_reset_req, pause_req;
    logic soft6, pause6;
    logic rst_n_out, sync_reset_out, clk_enable, gclk, ready;
    logic rst_n6, sync6, en6, gclk6, ready6;

    int checks = 0;
    int errors = 0;
    int gclk_rises = 0;
    int rises_before;

    always #5 clk = ~clk;

    always @(posedge gclk) gclk_rises++;

    reset_enable_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (4),
        .SOFT_CYCLES (1)
    ) dut (
        .clk            (clk),
        .async_reset    (async_reset),
        .soft_reset_req (soft_reset_req),
        .pause_req      (pause_req),
        .rst_n_out      (rst_n_out),
        .sync_reset_out (sync_reset_out),
        .clk_enable     (clk_enable),
        .gclk           (gclk),
        .ready          (ready)
    );

    reset_enable_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .SOFT_CYCLES (3)
    ) dut6 (
        .clk            (clk),
        .async_reset    (async_reset),
        .soft_reset_req (soft6),
        .pause_req      (pause6),
        .rst_n_out      (rst_n6),
        .sync_reset_out (sync6),
        .clk_enable     (en6),
        .gclk           (gclk6),
        .ready          (ready6)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_n"}, rst_n_out, 1'b0);
        chk({tag, "_sync"}, sync_reset_out, 1'b1);
        chk({tag, "_en"}, clk_enable, 1'b0);
        chk({tag, "_gclk"}, gclk, 1'b0);
        chk({tag, "_ready"}, ready, 1'b0);
        chk({tag, "_ready6"}, ready6, 1'b0);
    endtask

    // Called after async_reset falls mid-cycle, before E1.
    task automatic powerup(input string tag);
        tick(); // E1
        chk({tag, "_E1_rst_n"}, rst_n_out, 1'b0);
        chk({tag, "_E1_sync"}, sync_reset_out, 1'b1);
        tick(); // E2
        chk({tag, "_E2_rst_n"}, rst_n_out, 1'b1);
        chk({tag, "_E2_en"}, clk_enable, 1'b0);
        tick(); // E3
        chk({tag, "_E3_en"}, clk_enable, 1'b1);
        chk({tag, "_E3_sync"}, sync_reset_out, 1'b1);
        chk({tag, "_E3_ready"}, ready, 1'b0);
        chk({tag, "_E3_en6"}, en6, 1'b1);
        chk({tag, "_E3_ready6"}, ready6, 1'b0);
        tick(); // E4
        chk({tag, "_E4_ready6"}, ready6, 1'b1);
        chk({tag, "_E4_sync6"}, sync6, 1'b0);
        chk({tag, "_E4_ready"}, ready, 1'b0);
        tick(); // E5
        tick(); // E6
        chk({tag, "_E6_ready"}, ready, 1'b0);
        chk({tag, "_E6_sync"}, sync_reset_out, 1'b1);
        tick(); // E7
        chk({tag, "_E7_ready"}, ready, 1'b1);
        chk({tag, "_E7_sync"}, sync_reset_out, 1'b0);
        chk({tag, "_E7_en"}, clk_enable, 1'b1);
        chk({tag, "_E7_gclk"}, gclk, 1'b1);
    endtask

    initial begin
        async_reset    = 1'b1;
        soft_reset_req = 1'b0;
        pause_req      = 1'b0;
        soft6          = 1'b0;
        pause6         = 1'b0;

        // Reset held, check reset values, release mid-cycle after ~50ns.
        #22;
        chk_reset_vals("por");
        #30;
        async_reset = 1'b0;
        powerup("pu1");

        // Soft reset on the SOFT_CYCLES=3 instance: 3 clocks of sync reset.
        soft6 = 1'b1;
        tick();
        chk("soft3_c1_sync", sync6, 1'b1);
        chk("soft3_c1_en", en6, 1'b1);
        soft6 = 1'b0;
        tick();
        chk("soft3_c2_sync", sync6, 1'b1);
        tick();
        chk("soft3_c3_sync", sync6, 1'b1);
        chk("soft3_c3_ready", ready6, 1'b0);
        tick();
        chk("soft3_end_sync", sync6, 1'b0);
        chk("soft3_end_ready", ready6, 1'b1);

        // Single-cycle soft reset.
        soft_reset_req = 1'b1;
        tick();
        chk("soft_sync", sync_reset_out, 1'b1);
        chk("soft_en", clk_enable, 1'b1);
        chk("soft_ready", ready, 1'b0);
        soft_reset_req = 1'b0;
        tick();
        chk("soft_end_sync", sync_reset_out, 1'b0);
        chk("soft_end_ready", ready, 1'b1);

        // Pause for 5 clocks: gclk must stay flat once the latch closes.
        pause_req = 1'b1;
        tick();
        chk("pause_en", clk_enable, 1'b0);
        chk("pause_ready", ready, 1'b0);
        chk("pause_sync", sync_reset_out, 1'b0);
        #5;
        rises_before = gclk_rises;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pause_gclk", gclk, 1'b0);
        end
        pause_req = 1'b0;
        chk("pause_no_runt", 1'(gclk_rises != rises_before), 1'b0);
        tick();
        chk("pause_exit_ready", ready, 1'b1);
        chk("pause_exit_en", clk_enable, 1'b1);
        #5;
        tick();
        chk("pause_exit_gclk", gclk, 1'b1);

        // Soft and pause together: soft wins, then pause.
        soft_reset_req = 1'b1;
        pause_req      = 1'b1;
        tick();
        chk("both_sync", sync_reset_out, 1'b1);
        chk("both_en", clk_enable, 1'b1);
        soft_reset_req = 1'b0;
        tick();
        chk("both_run_ready", ready, 1'b1);
        tick();
        chk("both_pause_en", clk_enable, 1'b0);
        chk("both_pause_ready", ready, 1'b0);
        pause_req = 1'b0;
        tick();
        chk("both_resume_ready", ready, 1'b1);

        // Short reset pulse (2ns, no clock edge inside).
        async_reset = 1'b1;
        #1;
        chk_reset_vals("short");
        #1;
        async_reset = 1'b0;
        powerup("pu_short");

        // Reset during HOLD.
        async_reset = 1'b1;
        #2;
        async_reset = 1'b0;
        tick();
        tick();
        tick();
        chk("hold_reached_en", clk_enable, 1'b1);
        chk("hold_reached_ready", ready, 1'b0);
        #2;
        async_reset = 1'b1;
        #1;
        chk_reset_vals("rst_hold");
        #3;
        async_reset = 1'b0;
        powerup("pu_hold");

        // Reset during PAUSE.
        pause_req = 1'b1;
        tick();
        chk("pause2_en", clk_enable, 1'b0);
        #2;
        async_reset = 1'b1;
        pause_req   = 1'b0;
        #1;
        chk_reset_vals("rst_pause");
        #3;
        async_reset = 1'b0;
        powerup("pu_pause");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
